// File: rtl/program_sequencer_pkg.sv
// Shared constants, state encoding and opcode helpers for the program sequencer.
// The optional watchdog is enabled with SEQ_WATCHDOG_EN.
package program_sequencer_pkg;

    localparam logic [3:0] OP_JMPC = 4'b1100;
    localparam logic [3:0] OP_JMP  = 4'b1101;
    localparam logic [3:0] OP_HALT = 4'b1110;

    localparam int IMEM_DEPTH = 128;
    localparam int WDOG_LIMIT = 4095;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        COND,
        HALTED,
        FAULT
    } seqState_t;

    function automatic logic isDataOp(input logic [3:0] opcode);
        return !(opcode inside {OP_JMPC, OP_JMP, OP_HALT});
    endfunction

    function automatic logic pcInRange(input logic [7:0] pc);
        return (int'(pc) < IMEM_DEPTH);
    endfunction

endpackage

// File: rtl/program_select_encoder.sv
// Priority encoder: keeps only the lowest-numbered set bit of the program switches.
module program_select_encoder (
    input  logic [7:0] programSelect,
    output logic [7:0] oneHot
);

    // Two's-complement trick isolates the lowest set bit; zero stays zero.
    assign oneHot = programSelect & (~programSelect + 8'd1);

endmodule

// File: rtl/program_sequencer.sv
// Instruction fetch/issue sequencer with jumps, conditional jumps and halt.
// Defining SEQ_WATCHDOG_EN adds an instruction/jump budget and the watchdogTrip output.
//
// state  | meaning
// IDLE   | waiting for start; PC parked at 0
// FETCH  | capture instruction at PC into instrOut
// EXEC   | issue data op until execReady, or resolve JMP/JMPC/HALT
// COND   | sample condValue and resolve the conditional jump
// HALTED | program finished; only abort/reset leave
// FAULT  | bad select, out-of-range PC or watchdog; only abort/reset leave
module program_sequencer
    import program_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  programSelect,
    input  logic [15:0] instruction,
    input  logic [7:0]  condValue,
    input  logic        execReady,
    output logic [7:0]  address,
    output logic [7:0]  activeSelect,
    output logic [15:0] instrOut,
    output logic        instrValid,
    output logic [3:0]  condRegAddr,
    output logic        busy,
    output logic        halted,
`ifdef SEQ_WATCHDOG_EN
    output logic        watchdogTrip,
`endif
    output logic        fault
);

    seqState_t  state;
    logic [7:0] encodedSelect;
    logic [7:0] pcInc;
    logic [7:0] jmpTarget;
    logic [7:0] condTarget;
    logic [7:0] nextPc;
    logic       wdogExpire;
    logic       pcFault;
    logic [3:0] opcode;

    program_select_encoder u_encoder (
        .programSelect (programSelect),
        .oneHot        (encodedSelect)
    );

    assign opcode     = instrOut[15:12];
    assign pcInc      = address + 8'd1;
    assign jmpTarget  = pcInc + instrOut[7:0];
    assign condTarget = pcInc + {{4{instrOut[3]}}, instrOut[3:0]};

    always_comb begin
        nextPc = pcInc;
        if (state == EXEC && opcode == OP_JMP)
            nextPc = jmpTarget;
        else if (state == COND && condValue != 8'd0)
            nextPc = condTarget;
    end

    assign pcFault = !pcInRange(nextPc) || wdogExpire;

`ifdef SEQ_WATCHDOG_EN
    logic [11:0] wdogRemain;
    logic        wdogEvent;

    // Down-counter of remaining budget; the event that would consume the last unit trips.
    assign wdogEvent  = (state == EXEC && ((isDataOp(opcode) && execReady) || opcode == OP_JMP))
                     || (state == COND);
    assign wdogExpire = wdogEvent && (wdogRemain == 12'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            wdogRemain   <= 12'(WDOG_LIMIT);
            watchdogTrip <= 1'b0;
        end else if (!abort && state == IDLE && start) begin
            wdogRemain   <= 12'(WDOG_LIMIT);
            watchdogTrip <= 1'b0;
        end else if (!abort && wdogEvent) begin
            wdogRemain <= wdogRemain - 12'd1;
            if (wdogExpire)
                watchdogTrip <= 1'b1;
        end
    end
`else
    assign wdogExpire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            address      <= 8'd0;
            activeSelect <= 8'd0;
            instrOut     <= 16'd0;
            condRegAddr  <= 4'd0;
            instrValid   <= 1'b0;
        end else if (abort) begin
            state      <= IDLE;
            address    <= 8'd0;
            instrValid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (programSelect == 8'd0) begin
                            state <= FAULT;
                        end else begin
                            activeSelect <= encodedSelect;
                            address      <= 8'd0;
                            state        <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    instrOut   <= instruction;
                    instrValid <= isDataOp(instruction[15:12]);
                    if (instruction[15:12] == OP_JMPC)
                        condRegAddr <= instruction[7:4];
                    state <= EXEC;
                end
                EXEC: begin
                    if (opcode == OP_HALT) begin
                        state <= HALTED;
                    end else if (opcode == OP_JMPC) begin
                        state <= COND;
                    end else if (opcode == OP_JMP || execReady) begin
                        instrValid <= 1'b0;
                        if (pcFault) begin
                            state <= FAULT;
                        end else begin
                            address <= nextPc;
                            state   <= FETCH;
                        end
                    end
                end
                COND: begin
                    if (pcFault) begin
                        state <= FAULT;
                    end else begin
                        address <= nextPc;
                        state   <= FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state == FETCH) || (state == EXEC) || (state == COND);
    assign halted = (state == HALTED);
    assign fault  = (state == FAULT);

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer with a behavioural instruction memory.
module tb_program_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, abort, execReady;
    logic [7:0]  programSelect, condValue;
    logic [15:0] instruction;
    logic [7:0]  address, activeSelect;
    logic [15:0] instrOut;
    logic        instrValid, busy, halted, fault;
    logic [3:0]  condRegAddr;
`ifdef SEQ_WATCHDOG_EN
    logic        watchdogTrip;
`endif

    logic [15:0] mem [0:255];
    int          errors = 0;
    int          checks = 0;
    int          issues;
    logic [15:0] issuedWord;

    always #5 clk = ~clk;
    assign instruction = mem[address];

    program_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .programSelect (programSelect),
        .instruction   (instruction),
        .condValue     (condValue),
        .execReady     (execReady),
        .address       (address),
        .activeSelect  (activeSelect),
        .instrOut      (instrOut),
        .instrValid    (instrValid),
        .condRegAddr   (condRegAddr),
        .busy          (busy),
        .halted        (halted),
`ifdef SEQ_WATCHDOG_EN
        .watchdogTrip  (watchdogTrip),
`endif
        .fault         (fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clearMem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    initial begin
        clearMem();
        reset = 1'b1; start = 1'b0; abort = 1'b0; execReady = 1'b1;
        programSelect = 8'h00; condValue = 8'h00;
        tick(); tick();
        check("rst.address", 32'(address), 32'h0);
        check("rst.activeSelect", 32'(activeSelect), 32'h0);
        check("rst.instrOut", 32'(instrOut), 32'h0);
        check("rst.condRegAddr", 32'(condRegAddr), 32'h0);
        check("rst.instrValid", 32'(instrValid), 32'h0);
        check("rst.busy", 32'(busy), 32'h0);
        check("rst.halted", 32'(halted), 32'h0);
        check("rst.fault", 32'(fault), 32'h0);
`ifdef SEQ_WATCHDOG_EN
        check("rst.watchdogTrip", 32'(watchdogTrip), 32'h0);
`endif
        reset = 1'b0;

        // Data op then HALT: halted at cycle 5, a single issue
        mem[0] = 16'h0105; mem[1] = 16'hE000;
        programSelect = 8'h06; start = 1'b1; issues = 0; issuedWord = 16'h0;
        tick();
        check("A.activeSelect", 32'(activeSelect), 32'h02);
        check("A.busy", 32'(busy), 32'h1);
        check("A.address", 32'(address), 32'h0);
        start = 1'b0; programSelect = 8'h80;
        for (int c = 2; c <= 5; c++) begin
            tick();
            if (instrValid) begin
                issues++;
                issuedWord = instrOut;
            end
            if (c == 4) check("A.notHaltedC4", 32'(halted), 32'h0);
        end
        check("A.haltedC5", 32'(halted), 32'h1);
        check("A.issueCount", 32'(issues), 32'd1);
        check("A.issuedWord", 32'(issuedWord), 32'h0105);
        check("A.selectIgnored", 32'(activeSelect), 32'h02);
        start = 1'b1;
        tick();
        check("A.startIgnoredHalted", 32'(halted), 32'h1);
        start = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        check("A.abortBusy", 32'(busy), 32'h0);
        check("A.abortHalted", 32'(halted), 32'h0);
        check("A.abortAddress", 32'(address), 32'h0);
        check("A.abortKeepsSelect", 32'(activeSelect), 32'h02);

        // abort beats start in IDLE; start with no switches set faults
        start = 1'b1; abort = 1'b1; programSelect = 8'h01;
        tick();
        check("E.abortWinsBusy", 32'(busy), 32'h0);
        check("E.abortWinsSelect", 32'(activeSelect), 32'h02);
        abort = 1'b0; programSelect = 8'h00;
        tick();
        start = 1'b0;
        check("E.zeroSelectFault", 32'(fault), 32'h1);
        check("E.zeroSelectBusy", 32'(busy), 32'h0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("E.faultCleared", 32'(fault), 32'h0);

        // JMP to 6, JMPC 0xC051 taken -> 8
        clearMem();
        mem[0] = 16'hD005; mem[6] = 16'hC051; mem[7] = 16'hE000; mem[8] = 16'hE000;
        programSelect = 8'h50; condValue = 8'h01; start = 1'b1;
        tick();
        start = 1'b0;
        check("B.activeSelect", 32'(activeSelect), 32'h10);
        tick();
        check("B.jmpNoIssue", 32'(instrValid), 32'h0);
        tick();
        check("B.jmpTarget", 32'(address), 32'd6);
        tick();
        check("B.condRegAddr", 32'(condRegAddr), 32'h5);
        check("B.jmpcNoIssue", 32'(instrValid), 32'h0);
        tick();
        check("B.condBusy", 32'(busy), 32'h1);
        check("B.condAddress", 32'(address), 32'd6);
        tick();
        check("B.condTaken", 32'(address), 32'd8);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // abort in COND, rerun from 0 with condValue=0 -> 7
        condValue = 8'h00; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        check("F.inCond", 32'(address), 32'd6);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("F.abortBusy", 32'(busy), 32'h0);
        check("F.abortAddress", 32'(address), 32'h0);
        check("F.abortValid", 32'(instrValid), 32'h0);
        check("F.abortKeepsSelect", 32'(activeSelect), 32'h10);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("F.rerunBusy", 32'(busy), 32'h1);
        check("F.rerunAddress", 32'(address), 32'h0);
        tick(); tick(); tick(); tick();
        tick();
        check("F.condNotTaken", 32'(address), 32'd7);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // execReady stall, then reset in mid-EXEC
        clearMem();
        mem[0] = 16'h1234; mem[1] = 16'h2222;
        execReady = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("C.issueValid", 32'(instrValid), 32'h1);
        check("C.issueWord", 32'(instrOut), 32'h1234);
        for (int s = 0; s < 3; s++) begin
            tick();
            check("C.stallValid", 32'(instrValid), 32'h1);
            check("C.stallWord", 32'(instrOut), 32'h1234);
            check("C.stallPc", 32'(address), 32'h0);
        end
        execReady = 1'b1;
        tick();
        check("C.acceptValid", 32'(instrValid), 32'h0);
        check("C.acceptPc", 32'(address), 32'd1);
        execReady = 1'b0;
        tick();
        check("C.secondIssue", 32'(instrOut), 32'h2222);
        check("C.secondValid", 32'(instrValid), 32'h1);
        reset = 1'b1; start = 1'b1; abort = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0; abort = 1'b0; execReady = 1'b1;
        check("C.resetValid", 32'(instrValid), 32'h0);
        check("C.resetBusy", 32'(busy), 32'h0);
        check("C.resetAddress", 32'(address), 32'h0);
        check("C.resetSelect", 32'(activeSelect), 32'h0);

        // JMP 0xD07F at PC 10 -> 138 is out of range
        clearMem();
        mem[0] = 16'hD009; mem[10] = 16'hD07F;
        programSelect = 8'h01; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        check("D.atPc10", 32'(address), 32'd10);
        tick(); tick();
        check("D.fault", 32'(fault), 32'h1);
        check("D.faultValid", 32'(instrValid), 32'h0);
        check("D.faultBusy", 32'(busy), 32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("D.startIgnoredFault", 32'(fault), 32'h1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("D.faultCleared", 32'(fault), 32'h0);

`ifdef SEQ_WATCHDOG_EN
        begin
            int   faultCycle;
            logic preTrip;
            faultCycle = 0;
            preTrip = 1'bx;
            clearMem();
            mem[0] = 16'hD0FF;
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int c = 2; c <= 20000; c++) begin
                tick();
                if (c == 8190) preTrip = watchdogTrip;
                if (fault) begin
                    faultCycle = c;
                    break;
                end
            end
            check("W.faultCycle", 32'(faultCycle), 32'd8191);
            check("W.preTrip", 32'(preTrip), 32'h0);
            check("W.trip", 32'(watchdogTrip), 32'h1);
            check("W.address", 32'(address), 32'h0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
